// File: rtl/alu_sched.sv
// Round-robin arbiter feeding one shared combinational ALU; one op in flight, 2-cycle accept-to-response.
// Requests wait (req_ready low) while an op is executing or its response is stalled by rsp_ready.
module alu_sched #(
    parameter int BW   = 16,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*BW-1:0]  req_a,
    input  logic [NREQ*BW-1:0]  req_b,
    input  logic [NREQ*4-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [BW-1:0]       rsp_out,
    output logic [2:0]          rsp_flags,
    output logic                rsp_err,
    output logic [BW-1:0]       alu_a,
    output logic [BW-1:0]       alu_b,
    output logic [3:0]          alu_op,
    input  logic [BW-1:0]       alu_out,
    input  logic [2:0]          alu_flags,
    output logic [15:0]         op_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [BW-1:0]   alu_a_q, alu_a_d;
    logic [BW-1:0]   alu_b_q, alu_b_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [BW-1:0]   rsp_out_q, rsp_out_d;
    logic [2:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     op_count_q, op_count_d;

    logic [IW-1:0]   win_id;
    logic            win_vld;
    int              idx;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = IW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && win_vld)
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    id_d     = win_id;
                    alu_a_d  = req_a[int'(win_id)*BW +: BW];
                    alu_b_d  = req_b[int'(win_id)*BW +: BW];
                    alu_op_d = req_op[int'(win_id)*4 +: 4];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
                // Opcodes 8..15 have no ALU meaning; report zeros plus the error bit.
                if (alu_op_q[3]) begin
                    rsp_out_d   = '0;
                    rsp_flags_d = 3'b000;
                    rsp_err_d   = 1'b1;
                end else begin
                    rsp_out_d   = alu_out;
                    rsp_flags_d = alu_flags;
                    rsp_err_d   = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[id_q]) begin
                    rsp_valid_d = '0;
                    op_count_d  = op_count_q + 16'd1;
                    rr_ptr_d    = IW'((int'(id_q) + 1) % NREQ);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign op_count  = op_count_q;

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler sharing one combinational 16-bit ALU (opcodes 0–7, flags {overflow, negative, zero}) among NREQ independent requesters. Each requester issues operations over a valid/ready request channel and receives the registered result and flags on its own valid/ready response channel. The block sits between the requesters and the ALU instance: it drives the ALU operand and opcode ports and samples the ALU result and flags. Exactly one operation is in flight at a time.

## Interface
- BW, 16: ALU operand/result width.
- NREQ, 4: number of requesters (2..8).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*BW  operand A, requester i at [i*BW +: BW].
- req_b  in  NREQ*BW  operand B, same packing.
- req_op  in  NREQ*4  opcode, requester i at [i*4 +: 4].
- rsp_valid  out  NREQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_out  out  BW  result (shared bus, qualified by rsp_valid).
- rsp_flags  out  3  {overflow, negative, zero} from ALU.
- rsp_err  out  1  opcode was illegal (8–15).
- alu_a, alu_b  out  BW each  ALU operands (registered).
- alu_op  out  4  ALU opcode (registered).
- alu_out  in  BW  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_flags  in  3  ALU flags.
- op_count  out  16  completed-operation counter, wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: winner = first i with req_valid[i], searching from rr_ptr upward modulo NREQ. req_ready[winner]=1 combinationally; all other req_ready=0. On handshake: latch A, B, opcode and winner id into alu_a/alu_b/alu_op/id; go EXEC. No valid request: stay IDLE.
- EXEC: one cycle. At edge, capture alu_out→rsp_out and alu_flags→rsp_flags; go RESP. If latched opcode ≥ 8: capture rsp_out=0, rsp_flags=3'b000, rsp_err=1 instead; otherwise rsp_err=0.
- RESP: rsp_valid[id]=1. rsp_out/flags/err stable until rsp_ready[id]. On handshake: op_count+=1 (illegal opcodes also count), rr_ptr=(id+1) mod NREQ, go IDLE. rsp_ready on other lanes ignored.
- req_ready is 0 in EXEC and RESP; requests held valid wait.
- alu_a/alu_b/alu_op hold last latched values outside EXEC.
- Illegal opcode is forwarded to alu_op unchanged; ALU output ignored for that operation.

## Timing
- Reset (async, immediate): state=IDLE, rr_ptr=0, req_ready=0 while rst high, rsp_valid=0, rsp_out=0, rsp_flags=0, rsp_err=0, alu_a=alu_b=0, alu_op=0, op_count=0. In-flight operation dropped, no response issued.
- Latency: request handshake at edge N → rsp_valid high in cycle after edge N+1 (2 cycles). rsp_ready already high → IDLE at edge N+2; next grant possible in cycle after N+2. Peak throughput one op per 3 cycles.
- Grant decision is combinational on req_valid in IDLE; requester dropping req_valid before handshake loses grant with no side effect.
- rr_ptr updates only on response handshake; fairness: NREQ continuously requesting lanes each served once per NREQ operations.
- Results are signed two's complement, BW bits; no width extension.

## Test plan
- Single op: lane 0 A=10000, B=20000, op=0 → rsp_valid[0] 2 cycles after accept, rsp_out=30000, flags=3'b000, err=0, op_count=1.
- Overflow/flags: lane 2 A=20000, B=20000, op=0 → rsp_out=-25536, flags=3'b110; lane 1 A=10000, B=10000, op=1 → rsp_out=0, flags=3'b001.
- Round robin: all four lanes valid from reset with op=5 (A=i) → grants in order 0,1,2,3, results 1,2,3,4; lane 0 re-requesting after its response waits for lanes 1–3.
- Backpressure: rsp_ready[3] low 5 cycles during RESP → rsp_valid[3], rsp_out, rsp_flags stable, req_ready all 0, op_count unchanged until handshake.
- Illegal opcode: lane 1 op=4'b1001 → rsp_err=1, rsp_out=0, flags=0, op_count increments; next legal op returns err=0.
- Reset mid-op: assert rst during RESP → rsp_valid=0 immediately, op_count=0; after release, lane 0 granted first.
